// File: rtl/axil_arbiter.sv
// Round-robin arbiter that shares one AXI4-lite master port among S_COUNT requesters.
// The write and read paths arbitrate independently, and each allows one transaction in flight.
module axil_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]           s_axil_awprot,
  input  logic [S_COUNT-1:0]             s_axil_awvalid,
  output logic [S_COUNT-1:0]             s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0]  s_axil_wstrb,
  input  logic [S_COUNT-1:0]             s_axil_wvalid,
  output logic [S_COUNT-1:0]             s_axil_wready,
  output logic [S_COUNT*2-1:0]           s_axil_bresp,
  output logic [S_COUNT-1:0]             s_axil_bvalid,
  input  logic [S_COUNT-1:0]             s_axil_bready,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic [S_COUNT*3-1:0]           s_axil_arprot,
  input  logic [S_COUNT-1:0]             s_axil_arvalid,
  output logic [S_COUNT-1:0]             s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0]  s_axil_rdata,
  output logic [S_COUNT*2-1:0]           s_axil_rresp,
  output logic [S_COUNT-1:0]             s_axil_rvalid,
  input  logic [S_COUNT-1:0]             s_axil_rready,
  output logic [ADDR_WIDTH-1:0]          m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [DATA_WIDTH-1:0]          m_axil_wdata,
  output logic [STRB_WIDTH-1:0]          m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready,
  output logic [ADDR_WIDTH-1:0]          m_axil_araddr,
  output logic [2:0]                     m_axil_arprot,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready,
  input  logic [DATA_WIDTH-1:0]          m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready
);
  localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_RESP = 2'd2;

  // Returns {found, index}: the first requester at or after ptr, wrapping around.
  function automatic logic [IW:0] rr_pick(input logic [S_COUNT-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int j;
    res = '0;
    for (int k = S_COUNT-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % S_COUNT;
      if (req[j]) res = {1'b1, j[IW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (int'(g) == S_COUNT-1) ? '0 : g + 1'b1;
  endfunction

  logic [1:0]    r_wstate, r_rstate;
  logic [IW-1:0] r_wgnt, r_wptr, r_rgnt, r_rptr;
  logic          r_aw_done, r_w_done;
  logic [IW:0]   w_wpick, w_rpick;
  logic          w_waddr, w_wresp, w_raddr, w_rresp;
  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_wpick = rr_pick(s_axil_awvalid, r_wptr);
  assign w_rpick = rr_pick(s_axil_arvalid, r_rptr);
  assign w_waddr = (r_wstate == ST_ADDR);
  assign w_wresp = (r_wstate == ST_RESP);
  assign w_raddr = (r_rstate == ST_ADDR);
  assign w_rresp = (r_rstate == ST_RESP);

  assign m_axil_awaddr  = s_axil_awaddr[r_wgnt*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_awprot  = s_axil_awprot[r_wgnt*3 +: 3];
  assign m_axil_awvalid = w_waddr && !r_aw_done && s_axil_awvalid[r_wgnt];
  assign m_axil_wdata   = s_axil_wdata[r_wgnt*DATA_WIDTH +: DATA_WIDTH];
  assign m_axil_wstrb   = s_axil_wstrb[r_wgnt*STRB_WIDTH +: STRB_WIDTH];
  assign m_axil_wvalid  = w_waddr && !r_w_done && s_axil_wvalid[r_wgnt];
  assign m_axil_bready  = w_wresp && s_axil_bready[r_wgnt];
  assign m_axil_araddr  = s_axil_araddr[r_rgnt*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_arprot  = s_axil_arprot[r_rgnt*3 +: 3];
  assign m_axil_arvalid = w_raddr && s_axil_arvalid[r_rgnt];
  assign m_axil_rready  = w_rresp && s_axil_rready[r_rgnt];

  assign w_aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_w_hs  = m_axil_wvalid && m_axil_wready;
  assign w_b_hs  = m_axil_bvalid && m_axil_bready;
  assign w_ar_hs = m_axil_arvalid && m_axil_arready;
  assign w_r_hs  = m_axil_rvalid && m_axil_rready;

  // Only the granted port sees ready/valid or response data; all other ports read zero.
  always_comb begin
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    s_axil_bresp   = '0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    s_axil_rdata   = '0;
    s_axil_rresp   = '0;
    if (w_waddr) begin
      s_axil_awready[r_wgnt] = m_axil_awready && !r_aw_done;
      s_axil_wready[r_wgnt]  = m_axil_wready && !r_w_done;
    end
    if (w_wresp) begin
      s_axil_bvalid[r_wgnt]        = m_axil_bvalid;
      s_axil_bresp[r_wgnt*2 +: 2]  = m_axil_bresp;
    end
    if (w_raddr) s_axil_arready[r_rgnt] = m_axil_arready;
    if (w_rresp) begin
      s_axil_rvalid[r_rgnt]                         = m_axil_rvalid;
      s_axil_rdata[r_rgnt*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
      s_axil_rresp[r_rgnt*2 +: 2]                   = m_axil_rresp;
    end
  end

  // AW and W may complete in either order or together; both must finish before B is expected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= ST_IDLE;
      r_wgnt    <= '0;
      r_wptr    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        ST_IDLE: if (w_wpick[IW]) begin
          r_wgnt    <= w_wpick[IW-1:0];
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_wstate  <= ST_ADDR;
        end
        ST_ADDR: begin
          r_aw_done <= r_aw_done | w_aw_hs;
          r_w_done  <= r_w_done | w_w_hs;
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) r_wstate <= ST_RESP;
        end
        ST_RESP: if (w_b_hs) begin
          r_wstate <= ST_IDLE;
          r_wptr   <= rr_next(r_wgnt);
        end
        default: r_wstate <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= ST_IDLE;
      r_rgnt   <= '0;
      r_rptr   <= '0;
    end else begin
      case (r_rstate)
        ST_IDLE: if (w_rpick[IW]) begin
          r_rgnt   <= w_rpick[IW-1:0];
          r_rstate <= ST_ADDR;
        end
        ST_ADDR: if (w_ar_hs) r_rstate <= ST_RESP;
        ST_RESP: if (w_r_hs) begin
          r_rstate <= ST_IDLE;
          r_rptr   <= rr_next(r_rgnt);
        end
        default: r_rstate <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_arbiter.sv
// Bench for axil_arbiter with four ports. A negedge model plays requesters and the shared slave.
// Expectations are queued as stimulus is issued and then compared when handshakes occur.
module tb_axil_arbiter;
  localparam int S = 4, DW = 32, AW = 32, SW = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [S*AW-1:0] s_axil_awaddr, s_axil_araddr;
  logic [S*3-1:0]  s_axil_awprot, s_axil_arprot;
  logic [S-1:0]    s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [S*DW-1:0] s_axil_wdata, s_axil_rdata;
  logic [S*SW-1:0] s_axil_wstrb;
  logic [S*2-1:0]  s_axil_bresp, s_axil_rresp;
  logic [S-1:0]    s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready, s_axil_rvalid, s_axil_rready;
  logic [AW-1:0]   m_axil_awaddr, m_axil_araddr;
  logic [2:0]      m_axil_awprot, m_axil_arprot;
  logic            m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0]   m_axil_wdata, m_axil_rdata;
  logic [SW-1:0]   m_axil_wstrb;
  logic [1:0]      m_axil_bresp, m_axil_rresp;
  logic            m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;

  axil_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
    .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
    .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  // requester model state
  bit          wr_go[S], wr_busy[S], aw_v[S], w_v[S], w_todo[S], ar_v[S], rd_busy[S];
  int          w_lag[S], w_lagc[S], rd_rem[S], rd_k[S];
  logic [31:0] wr_addr[S], wr_data[S], rd_base[S], rd_cur[S];
  // shared slave model state
  bit          sl_aw_got, sl_w_got, sl_bv, sl_rv, b_hold, rd_fixed_en;
  logic [31:0] sl_rdat, rd_fixed;
  logic [1:0]  bresp_k, rresp_k;
  // scoreboard
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$], exp_rdata[$];
  int          exp_bport[$], exp_rport[$];
  logic [1:0]  exp_bresp[$], exp_rresp[$];
  // monitor results
  int          cyc, aw_hs_n, w_hs_n, aw_cyc, ar_cyc, b_cyc[S], gr_n[S];
  logic [S-1:0] b_mask;
  int          n_checks, n_errors;
  int          t_p;
  logic [31:0] t_d;
  logic [1:0]  t_r;

  function automatic logic [9:0] outs();
    return {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready,
            |s_axil_awready, |s_axil_wready, |s_axil_bvalid, |s_axil_arready, |s_axil_rvalid};
  endfunction

  // t+1: drive every DUT input from the model; t+2: observe the handshakes of the coming posedge
  always @(negedge clk) begin
    #1;
    if (rst) begin
      for (int p = 0; p < S; p++) begin
        wr_go[p] = 0; wr_busy[p] = 0; aw_v[p] = 0; w_v[p] = 0; w_todo[p] = 0;
        ar_v[p] = 0; rd_busy[p] = 0; rd_rem[p] = 0;
      end
      sl_aw_got = 0; sl_w_got = 0; sl_bv = 0; sl_rv = 0;
    end else begin
      for (int p = 0; p < S; p++) begin
        if (wr_go[p] && !wr_busy[p]) begin
          wr_go[p] = 0; wr_busy[p] = 1; aw_v[p] = 1; w_todo[p] = 1;
          w_lagc[p] = w_lag[p]; w_v[p] = (w_lag[p] == 0);
        end
        if (rd_rem[p] > 0 && !rd_busy[p]) begin
          rd_busy[p] = 1; ar_v[p] = 1; rd_cur[p] = rd_base[p] + rd_k[p]*4;
        end
      end
    end
    for (int p = 0; p < S; p++) begin
      s_axil_awvalid[p] = aw_v[p];
      s_axil_awaddr[p*AW +: AW] = wr_addr[p];
      s_axil_awprot[p*3 +: 3] = 3'(p);
      s_axil_wvalid[p] = w_v[p];
      s_axil_wdata[p*DW +: DW] = wr_data[p];
      s_axil_wstrb[p*SW +: SW] = 4'hF;
      s_axil_bready[p] = 1'b1;
      s_axil_arvalid[p] = ar_v[p];
      s_axil_araddr[p*AW +: AW] = rd_cur[p];
      s_axil_arprot[p*3 +: 3] = 3'd0;
      s_axil_rready[p] = 1'b1;
    end
    m_axil_awready = !rst; m_axil_wready = !rst; m_axil_arready = !rst;
    m_axil_bvalid = sl_bv && !b_hold; m_axil_bresp = bresp_k;
    m_axil_rvalid = sl_rv; m_axil_rdata = sl_rdat; m_axil_rresp = rresp_k;
    #1;
    if (!rst) begin
      cyc++;
      if (m_axil_bvalid && m_axil_bready) sl_bv = 0;
      if (m_axil_awvalid && m_axil_awready) begin
        aw_hs_n++; aw_cyc = cyc; sl_aw_got = 1; n_checks++;
        if (exp_aw.size() == 0) begin n_errors++; $display("FAIL m_aw unexpected addr=%h", m_axil_awaddr); end
        else begin t_d = exp_aw.pop_front();
          if (m_axil_awaddr !== t_d) begin n_errors++; $display("FAIL m_awaddr got=%h exp=%h", m_axil_awaddr, t_d); end
        end
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_hs_n++; sl_w_got = 1; n_checks++;
        if (exp_w.size() == 0) begin n_errors++; $display("FAIL m_w unexpected data=%h", m_axil_wdata); end
        else begin t_d = exp_w.pop_front();
          if (m_axil_wdata !== t_d) begin n_errors++; $display("FAIL m_wdata got=%h exp=%h", m_axil_wdata, t_d); end
        end
      end
      if (sl_aw_got && sl_w_got) begin sl_bv = 1; sl_aw_got = 0; sl_w_got = 0; end
      if (m_axil_rvalid && m_axil_rready) sl_rv = 0;
      if (m_axil_arvalid && m_axil_arready) begin
        ar_cyc = cyc; sl_rv = 1;
        sl_rdat = rd_fixed_en ? rd_fixed : (m_axil_araddr ^ 32'hA5A5_0000);
        gr_n[m_axil_araddr[9:8]]++; n_checks++;
        if (exp_ar.size() == 0) begin n_errors++; $display("FAIL m_ar unexpected addr=%h", m_axil_araddr); end
        else begin t_d = exp_ar.pop_front();
          if (m_axil_araddr !== t_d) begin n_errors++; $display("FAIL m_araddr got=%h exp=%h", m_axil_araddr, t_d); end
        end
      end
      b_mask |= s_axil_bvalid;
      for (int p = 0; p < S; p++) begin
        if (s_axil_awvalid[p] && s_axil_awready[p]) aw_v[p] = 0;
        if (s_axil_wvalid[p] && s_axil_wready[p]) begin w_v[p] = 0; w_todo[p] = 0; end
        else if (w_todo[p] && !w_v[p]) begin
          if (w_lagc[p] <= 1) w_v[p] = 1; else w_lagc[p]--;
        end
        if (s_axil_bvalid[p] && s_axil_bready[p]) begin
          wr_busy[p] = 0; b_cyc[p] = cyc; n_checks++;
          if (exp_bport.size() == 0) begin n_errors++; $display("FAIL s_b unexpected port=%0d", p); end
          else begin t_p = exp_bport.pop_front(); t_r = exp_bresp.pop_front();
            if (p != t_p || s_axil_bresp[p*2 +: 2] !== t_r) begin
              n_errors++; $display("FAIL s_b port=%0d resp=%0d exp port=%0d resp=%0d", p, s_axil_bresp[p*2 +: 2], t_p, t_r);
            end
          end
        end
        if (s_axil_arvalid[p] && s_axil_arready[p]) ar_v[p] = 0;
        if (s_axil_rvalid[p] && s_axil_rready[p]) begin
          rd_busy[p] = 0; rd_rem[p]--; rd_k[p]++; n_checks++;
          if (exp_rport.size() == 0) begin n_errors++; $display("FAIL s_r unexpected port=%0d", p); end
          else begin t_p = exp_rport.pop_front(); t_d = exp_rdata.pop_front(); t_r = exp_rresp.pop_front();
            if (p != t_p || s_axil_rdata[p*DW +: DW] !== t_d || s_axil_rresp[p*2 +: 2] !== t_r) begin
              n_errors++; $display("FAIL s_r port=%0d data=%h resp=%0d exp port=%0d data=%h resp=%0d",
                                   p, s_axil_rdata[p*DW +: DW], s_axil_rresp[p*2 +: 2], t_p, t_d, t_r);
            end
          end
          n_checks++;
          if ((s_axil_rdata & ~({{(S*DW-DW){1'b0}}, {DW{1'b1}}} << (p*DW))) !== '0) begin
            n_errors++; $display("FAIL rdata_iso other ports nonzero got=%h", s_axil_rdata);
          end
        end
      end
    end
  end

  task automatic wait_quiet(input string name);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk); #3;
      busy = sl_bv || sl_rv;
      for (int p = 0; p < S; p++) busy |= wr_go[p] || wr_busy[p] || rd_busy[p] || (rd_rem[p] > 0);
      n++;
    end while (busy && n < 1000);
    n_checks++;
    if (busy) begin n_errors++; $display("FAIL %s timeout got=busy exp=idle", name); end
    n_checks++;
    if (exp_aw.size() + exp_w.size() + exp_bport.size() + exp_ar.size() + exp_rport.size() != 0) begin
      n_errors++;
      $display("FAIL %s leftover got=%0d/%0d/%0d/%0d/%0d exp=0", name, exp_aw.size(), exp_w.size(),
               exp_bport.size(), exp_ar.size(), exp_rport.size());
    end
  endtask

  task automatic queue_write(input int p, input logic [31:0] a, input logic [31:0] d, input int lag, input logic [1:0] resp);
    wr_addr[p] = a; wr_data[p] = d; w_lag[p] = lag;
    exp_aw.push_back(a); exp_w.push_back(d); exp_bport.push_back(p); exp_bresp.push_back(resp);
  endtask

  task automatic test_reset();
    logic [9:0] acc;
    repeat (3) @(negedge clk);
    #3; n_checks++;
    if (outs() !== 10'd0) begin n_errors++; $display("FAIL reset_outs got=%b exp=0", outs()); end
    @(negedge clk); rst = 1'b0;
    acc = '0;
    repeat (100) begin @(negedge clk); #3; acc |= outs(); end
    n_checks++;
    if (acc[9:5] !== 5'd0) begin n_errors++; $display("FAIL idle_m_outs got=%b exp=0", acc[9:5]); end
    n_checks++;
    if (acc[4:0] !== 5'd0) begin n_errors++; $display("FAIL idle_s_outs got=%b exp=0", acc[4:0]); end
  endtask

  task automatic test_simul_writes();
    @(negedge clk);
    bresp_k = 2'd0;
    queue_write(0, 32'h100, 32'h1111_1111, 0, 2'd0);
    queue_write(1, 32'h104, 32'h2222_2222, 0, 2'd0);
    wr_go[0] = 1; wr_go[1] = 1;
    wait_quiet("simul_writes");
    n_checks++;
    if (!(b_cyc[1] > b_cyc[0])) begin n_errors++; $display("FAIL b_order got p1=%0d p0=%0d exp p1>p0", b_cyc[1], b_cyc[0]); end
  endtask

  task automatic test_port1_write();
    @(negedge clk);
    aw_hs_n = 0; w_hs_n = 0; b_mask = '0; bresp_k = 2'd3;
    queue_write(1, 32'h10, 32'hDEAD_BEEF, 3, 2'd3);
    wr_go[1] = 1;
    wait_quiet("port1_write");
    n_checks++;
    if (aw_hs_n != 1 || w_hs_n != 1) begin n_errors++; $display("FAIL single_hs got aw=%0d w=%0d exp 1/1", aw_hs_n, w_hs_n); end
    n_checks++;
    if (b_mask !== 4'b0010) begin n_errors++; $display("FAIL bvalid_mask got=%b exp=0010", b_mask); end
    bresp_k = 2'd0;
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    rd_fixed_en = 1; rd_fixed = 32'h1234; rresp_k = 2'd2;
    rd_base[0] = 32'h20; rd_k[0] = 0;
    exp_ar.push_back(32'h20); exp_rport.push_back(0); exp_rdata.push_back(32'h1234); exp_rresp.push_back(2'd2);
    queue_write(1, 32'h30, 32'hCAFE_F00D, 0, 2'd0);
    rd_rem[0] = 1; wr_go[1] = 1;
    wait_quiet("concurrent");
    n_checks++;
    if (ar_cyc != aw_cyc) begin n_errors++; $display("FAIL parallel got ar_cyc=%0d aw_cyc=%0d exp equal", ar_cyc, aw_cyc); end
    rd_fixed_en = 0; rresp_k = 2'd0;
  endtask

  task automatic test_reset_wresp();
    int n;
    @(negedge clk);
    b_hold = 1;
    wr_addr[2] = 32'h200; wr_data[2] = 32'h3333_3333; w_lag[2] = 0;
    exp_aw.push_back(32'h200); exp_w.push_back(32'h3333_3333);
    wr_go[2] = 1;
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!sl_bv && n < 50);
    n_checks++;
    if (!sl_bv) begin n_errors++; $display("FAIL wresp_reach timeout got=0 exp=1"); end
    @(negedge clk); #3;
    n_checks++;
    if (m_axil_bready !== 1'b1) begin n_errors++; $display("FAIL wresp_bready got=%b exp=1", m_axil_bready); end
    rst = 1'b1;
    #1; n_checks++;
    if (outs() !== 10'd0) begin n_errors++; $display("FAIL rst_outs got=%b exp=0", outs()); end
    exp_aw.delete(); exp_w.delete(); exp_bport.delete(); exp_bresp.delete();
    exp_ar.delete(); exp_rport.delete(); exp_rdata.delete(); exp_rresp.delete();
    repeat (2) @(negedge clk);
    b_hold = 0; rst = 1'b0;
    @(negedge clk);
    queue_write(1, 32'h210, 32'h4444_4444, 0, 2'd0);
    queue_write(3, 32'h230, 32'h5555_5555, 0, 2'd0);
    wr_go[1] = 1; wr_go[3] = 1;
    wait_quiet("post_reset_writes");
  endtask

  task automatic test_rr_reads();
    @(negedge clk);
    for (int p = 0; p < S; p++) begin rd_base[p] = 32'h1000 + p*32'h100; rd_k[p] = 0; gr_n[p] = 0; end
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < S; p++) begin
        t_d = 32'h1000 + p*32'h100 + r*4;
        exp_ar.push_back(t_d); exp_rport.push_back(p);
        exp_rdata.push_back(t_d ^ 32'hA5A5_0000); exp_rresp.push_back(2'd0);
      end
    for (int p = 0; p < S; p++) rd_rem[p] = 4;
    wait_quiet("rr_reads");
    for (int p = 0; p < S; p++) begin
      n_checks++;
      if (gr_n[p] != 4) begin n_errors++; $display("FAIL grant_count port%0d got=%0d exp=4", p, gr_n[p]); end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; b_mask = '0;
    b_hold = 0; rd_fixed_en = 0; rd_fixed = '0; bresp_k = '0; rresp_k = '0; sl_rdat = '0;
    for (int p = 0; p < S; p++) begin
      wr_addr[p] = '0; wr_data[p] = '0; rd_base[p] = '0; rd_cur[p] = '0; w_lag[p] = 0; rd_k[p] = 0; b_cyc[p] = 0;
    end
    test_reset();
    test_simul_writes();
    test_port1_write();
    test_concurrent();
    test_reset_wresp();
    test_rr_reads();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
